// File: rtl/uart_program_loader.sv
// UART program loader: receives a framed program image over 8N1 serial and issues
// one-cycle word writes into instruction memory, holding the core in reset while busy.
module uart_program_loader #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {L_IDLE, L_COUNT, L_DATA, L_CHECK} ld_state_e;

  logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ferr_q, rx_ferr_d;

  ld_state_e        ld_state_q, ld_state_d;
  logic [8:0]       words_left_q, words_left_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       csum_q, csum_d;
  logic             we_q, we_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= RX_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

  // Receiver: mid-bit sampling, start-bit glitch rejection, stop-bit framing check
  always_comb begin
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    rx_ferr_d  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        bit_cnt_d = '0;
        if (rxd_prev_q && !rxd_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (bit_cnt_q == CNT_W'(HALF_BIT - 1)) begin
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d = '0;
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          if (rxd_sync_q) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shift_q;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state_q   <= L_IDLE;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ld_state_q   <= ld_state_d;
      words_left_q <= words_left_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Frame loader: sync, word count, little-endian words, XOR checksum
  always_comb begin
    ld_state_d   = ld_state_q;
    words_left_d = words_left_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    csum_d       = csum_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    if (we_q) waddr_d = waddr_q + 32'd4;
    unique case (ld_state_q)
      L_IDLE: begin
        if (rx_valid_q && (rx_byte_q == SYNC_BYTE)) begin
          ld_state_d = L_COUNT;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          waddr_d    = '0;
          csum_d     = '0;
        end
      end
      L_COUNT: begin
        if (rx_valid_q) begin
          words_left_d = (rx_byte_q == 8'd0) ? 9'd256 : {1'b0, rx_byte_q};
          byte_idx_d   = '0;
          ld_state_d   = L_DATA;
        end
      end
      L_DATA: begin
        if (rx_valid_q) begin
          csum_d     = csum_q ^ rx_byte_q;
          word_d     = {rx_byte_q, word_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d         = 1'b1;
            wdata_d      = {rx_byte_q, word_q[31:8]};
            words_left_d = words_left_q - 9'd1;
            if (words_left_q == 9'd1) ld_state_d = L_CHECK;
          end
        end
      end
      L_CHECK: begin
        if (rx_valid_q) begin
          done_d     = (rx_byte_q == csum_q);
          err_d      = (rx_byte_q != csum_q);
          busy_d     = 1'b0;
          ld_state_d = L_IDLE;
        end
      end
      default: ld_state_d = L_IDLE;
    endcase
    // A framing error aborts any frame in progress; completed writes are kept
    if (rx_ferr_q && (ld_state_q != L_IDLE)) begin
      err_d      = 1'b1;
      busy_d     = 1'b0;
      ld_state_d = L_IDLE;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: serial frame driver, queue-based write model and
// per-cycle write checker, with directed and randomized frames.
module tb_uart_program_loader;

  localparam int unsigned BIT_CLKS = 10;

  logic        clk;
  logic        rst_n;
  logic        rxd;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;

  int          n_checks;
  int          n_fail;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        exp_done;
  logic        exp_err;
  logic [31:0] exp_waddr;
  logic [7:0]  last_csum;
  logic [31:0] wbuf[0:7];

  uart_program_loader #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk  (clk),
    .rst  (rst_n),
    .rxd  (rxd),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        check("we_waddr", waddr, exp_addr_q.pop_front());
        check("we_wdata", wdata, exp_data_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (BIT_CLKS) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT_CLKS + 2) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input bit corrupt);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    send_byte(8'hA5, 1'b1);
    check("busy_after_sync", 32'(busy), 32'd1);
    check("done_clr_on_sync", 32'(done), 32'd0);
    check("err_clr_on_sync", 32'(err), 32'd0);
    send_byte(8'(n), 1'b1);
    for (int w = 0; w < n; w++) begin
      exp_addr_q.push_back(32'(4 * w));
      exp_data_q.push_back(wbuf[w]);
      for (int k = 0; k < 4; k++) begin
        b  = wbuf[w][8*k +: 8];
        cs = cs ^ b;
        send_byte(b, 1'b1);
      end
    end
    last_csum = cs;
    send_byte(corrupt ? (cs ^ 8'h01) : cs, 1'b1);
    exp_done  = !corrupt;
    exp_err   = corrupt;
    exp_waddr = 32'(4 * n);
  endtask

  task automatic check_settled(input string tag);
    repeat (2 * BIT_CLKS) @(negedge clk);
    check({tag, "_pending_writes"}, 32'(exp_addr_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_waddr"}, waddr, exp_waddr);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] cs;
    int         n;
    n_checks  = 0;
    n_fail    = 0;
    rxd       = 1'b1;
    rst_n     = 1'b0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_waddr = 32'd0;
    last_csum = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", waddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single-word frame with hand-computed checksum
    wbuf[0] = 32'h00A00513;
    send_frame(1, 1'b0);
    check("t1_model_csum", 32'(last_csum), 32'h0000_00B6);
    check_settled("t1");
    check("t1_wdata_hold", wdata, 32'h00A00513);

    // Two words, good then corrupted checksum
    wbuf[0] = 32'h00500093;
    wbuf[1] = 32'h00108133;
    send_frame(2, 1'b0);
    check_settled("t2_good");
    send_frame(2, 1'b1);
    check_settled("t2_bad");

    // Noise before sync is ignored and sticky err holds
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h13, 1'b1);
    check_settled("t3_noise");
    wbuf[0] = 32'hDEADBEEF;
    send_frame(1, 1'b0);
    check_settled("t3_frame");

    // Framing error on third data byte aborts without a write
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("t4_busy_mid", 32'(busy), 32'd1);
    send_byte(8'h33, 1'b0);
    exp_done = 1'b0; exp_err = 1'b1; exp_waddr = 32'd0;
    check_settled("t4_abort");
    wbuf[0] = 32'h12345678;
    send_frame(1, 1'b0);
    check_settled("t4_recover");

    // Short low glitch while idle
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * BIT_CLKS) @(negedge clk);
    check_settled("t5_glitch");
    wbuf[0] = 32'hCAFEF00D;
    wbuf[1] = 32'h0BADC0DE;
    send_frame(2, 1'b0);
    check_settled("t5_after");

    // Asynchronous reset mid-word
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_we", 32'(we), 32'd0);
    check("t6_waddr", waddr, 32'd0);
    check("t6_wdata", wdata, 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    wbuf[0] = 32'h76543210;
    send_frame(1, 1'b0);
    check_settled("t6_after");

    // Count byte 0 means 256 words: still busy after five words, then abort
    cs = 8'h00;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int w = 0; w < 5; w++) begin
      wbuf[w] = $urandom;
      exp_addr_q.push_back(32'(4 * w));
      exp_data_q.push_back(wbuf[w]);
      for (int k = 0; k < 4; k++) begin
        b  = wbuf[w][8*k +: 8];
        cs = cs ^ b;
        send_byte(b, 1'b1);
      end
    end
    check("t7_busy_n0", 32'(busy), 32'd1);
    send_byte(cs, 1'b0);
    exp_done = 1'b0; exp_err = 1'b1; exp_waddr = 32'd20;
    check_settled("t7_abort");

    // Randomized frames with optional leading noise and corrupted checksums
    for (int f = 0; f < 6; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, 1'b1);
      end
      n = int'($urandom_range(1, 4));
      for (int w = 0; w < n; w++) wbuf[w] = $urandom;
      send_frame(n, ($urandom_range(0, 2) == 0));
      check_settled("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
